// File: rtl/kgp_multicycle_ctrl.sv
// Multi-cycle control sequencer for the KGP-RISC datapath: fetch, decode, ALU, memory, writeback.
// Optional handshake watchdog enabled by defining CTRL_TIMEOUT_EN.
module kgp_multicycle_ctrl #(
`ifdef CTRL_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 255,
`endif
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           opcode,
  input  logic [3:0]           fcode,
  input  logic                 cond_true,
  input  logic                 imem_ack,
  input  logic                 alu_done,
  input  logic                 dmem_ack,
  output logic                 imem_req,
  output logic                 ir_load,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 alu_start,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 flag_write,
  output logic                 halted,
  output logic                 illegal,
  output logic                 timeout,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] retired_count
);

  // Handshake rule: a req is held high until its ack is sampled high at a
  // rising edge, then drops on that edge; an ack seen while req is low is ignored.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t     state_q, state_n;
  logic       imem_req_n, ir_load_n, pc_write_n, alu_start_n, dmem_req_n, dmem_we_n;
  logic       reg_write_n, mem_to_reg_n, flag_write_n, halted_n, illegal_n;
  logic [1:0] pc_src_n;
  logic       legal, retire;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      3'b000:         legal = (fcode <= 4'd11);
      3'b001, 3'b010: legal = (fcode <= 4'd1);
      3'b011:         legal = (fcode <= 4'd10);
      default:        legal = 1'b0;
    endcase
  end

`ifdef CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wait_cnt, wait_cnt_n;
  logic          timeout_n, waiting, expired;
`endif

  always_comb begin
    state_n      = state_q;
    imem_req_n   = 1'b0;
    ir_load_n    = 1'b0;
    pc_write_n   = 1'b0;
    pc_src_n     = 2'b00;
    alu_start_n  = 1'b0;
    dmem_req_n   = 1'b0;
    dmem_we_n    = 1'b0;
    reg_write_n  = 1'b0;
    mem_to_reg_n = 1'b0;
    flag_write_n = 1'b0;
    halted_n     = halted;
    illegal_n    = illegal;
    retire       = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_n    = S_FETCH;
        imem_req_n = 1'b1;
      end
      S_FETCH: begin
        if (imem_ack) begin
          state_n    = S_DECODE;
          ir_load_n  = 1'b1;
          pc_write_n = 1'b1;
        end else begin
          imem_req_n = 1'b1;
        end
      end
      S_DECODE: begin
        if (opcode == 3'b100) begin
          state_n  = S_HALT;
          halted_n = 1'b1;
        end else if (!legal) begin
          state_n   = S_HALT;
          halted_n  = 1'b1;
          illegal_n = 1'b1;
        end else begin
          state_n     = S_EXEC;
          alu_start_n = 1'b1;
        end
      end
      S_EXEC: begin
        if (alu_done) begin
          case (opcode)
            3'b000, 3'b001: begin
              state_n      = S_WB;
              reg_write_n  = 1'b1;
              flag_write_n = 1'b1;
            end
            3'b010: begin
              state_n    = S_MEM;
              dmem_req_n = 1'b1;
              dmem_we_n  = (fcode == 4'd1);
            end
            default: begin
              state_n    = S_FETCH;
              imem_req_n = 1'b1;
              retire     = 1'b1;
              // fcode 0 is jr; the other branch forms follow the flag condition
              if (fcode == 4'd0) begin
                pc_write_n = 1'b1;
                pc_src_n   = 2'b10;
              end else if (cond_true) begin
                pc_write_n = 1'b1;
                pc_src_n   = 2'b01;
              end
            end
          endcase
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (fcode == 4'd1) begin
            state_n    = S_FETCH;
            imem_req_n = 1'b1;
            retire     = 1'b1;
          end else begin
            state_n      = S_WB;
            reg_write_n  = 1'b1;
            mem_to_reg_n = 1'b1;
          end
        end else begin
          dmem_req_n = 1'b1;
          dmem_we_n  = (fcode == 4'd1);
        end
      end
      S_WB: begin
        state_n    = S_FETCH;
        imem_req_n = 1'b1;
        retire     = 1'b1;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase

`ifdef CTRL_TIMEOUT_EN
    timeout_n = timeout;
    waiting   = (state_q == S_FETCH && !imem_ack) ||
                (state_q == S_EXEC  && !alu_done) ||
                (state_q == S_MEM   && !dmem_ack);
    expired   = waiting && (wait_cnt == WAIT_LAST);
    if (expired) begin
      state_n    = S_HALT;
      imem_req_n = 1'b0;
      dmem_req_n = 1'b0;
      dmem_we_n  = 1'b0;
      halted_n   = 1'b1;
      timeout_n  = 1'b1;
    end
    // Counter restarts whenever the state changes, so each wait is timed on its own
    if (state_n != state_q) begin
      wait_cnt_n = '0;
    end else if (waiting) begin
      wait_cnt_n = wait_cnt + 1'b1;
    end else begin
      wait_cnt_n = wait_cnt;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      imem_req      <= 1'b0;
      ir_load       <= 1'b0;
      pc_write      <= 1'b0;
      pc_src        <= 2'b00;
      alu_start     <= 1'b0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      reg_write     <= 1'b0;
      mem_to_reg    <= 1'b0;
      flag_write    <= 1'b0;
      halted        <= 1'b0;
      illegal       <= 1'b0;
      retired_count <= '0;
    end else begin
      state_q       <= state_n;
      imem_req      <= imem_req_n;
      ir_load       <= ir_load_n;
      pc_write      <= pc_write_n;
      pc_src        <= pc_src_n;
      alu_start     <= alu_start_n;
      dmem_req      <= dmem_req_n;
      dmem_we       <= dmem_we_n;
      reg_write     <= reg_write_n;
      mem_to_reg    <= mem_to_reg_n;
      flag_write    <= flag_write_n;
      halted        <= halted_n;
      illegal       <= illegal_n;
      if (retire) retired_count <= retired_count + CNT_WIDTH'(1);
    end
  end

`ifdef CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_n;
      timeout  <= timeout_n;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign state = state_q;

endmodule

// File: tb/tb_kgp_multicycle_ctrl.sv
// Directed bench for kgp_multicycle_ctrl; covers the CTRL_TIMEOUT_EN watchdog when that macro is defined.
module tb_kgp_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  opcode = '0;
  logic [3:0]  fcode = '0;
  logic        cond_true = 1'b0;
  logic        imem_ack = 1'b0;
  logic        alu_done = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, ir_load, pc_write, alu_start, dmem_req, dmem_we;
  logic        reg_write, mem_to_reg, flag_write, halted, illegal, timeout;
  logic [1:0]  pc_src;
  logic [2:0]  state;
  logic [31:0] retired_count;

  int total = 0;
  int bad = 0;

  // clock / reset block
  always #5 clk = ~clk;

  kgp_multicycle_ctrl #(
`ifdef CTRL_TIMEOUT_EN
    .TIMEOUT_CYCLES(8),
`endif
    .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .fcode(fcode), .cond_true(cond_true),
    .imem_ack(imem_ack), .alu_done(alu_done), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src),
    .alu_start(alu_start), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .flag_write(flag_write),
    .halted(halted), .illegal(illegal), .timeout(timeout), .state(state),
    .retired_count(retired_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // all driving and sampling happens 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".state"}, state, 0);
    check({tag, ".imem_req"}, imem_req, 0);
    check({tag, ".ir_load"}, ir_load, 0);
    check({tag, ".pc_write"}, pc_write, 0);
    check({tag, ".pc_src"}, pc_src, 0);
    check({tag, ".alu_start"}, alu_start, 0);
    check({tag, ".dmem_req"}, dmem_req, 0);
    check({tag, ".dmem_we"}, dmem_we, 0);
    check({tag, ".reg_write"}, reg_write, 0);
    check({tag, ".mem_to_reg"}, mem_to_reg, 0);
    check({tag, ".flag_write"}, flag_write, 0);
    check({tag, ".halted"}, halted, 0);
    check({tag, ".illegal"}, illegal, 0);
    check({tag, ".timeout"}, timeout, 0);
    check({tag, ".retired"}, retired_count, 0);
  endtask

  // asserts reset mid-cycle, checks it, releases; returns in the first FETCH cycle
  task automatic apply_reset(input string tag);
    rst = 1'b0;
    imem_ack = 0; alu_done = 0; dmem_ack = 0; cond_true = 0;
    #1;
    check_zero(tag);
    step();
    rst = 1'b1;
    check({tag, ".rel_idle"}, state, 0);
    step();
    check({tag, ".rel_fetch"}, state, 1);
    check({tag, ".rel_req"}, imem_req, 1);
  endtask

  // called in a FETCH cycle; acks after nwait extra cycles; returns in DECODE
  task automatic do_fetch(input logic [2:0] op, input logic [3:0] fc, input int nwait);
    for (int i = 0; i < nwait; i++) begin
      check("fetch_wait_req", imem_req, 1);
      check("fetch_wait_state", state, 1);
      step();
    end
    check("fetch_req", imem_req, 1);
    imem_ack = 1'b1;
    opcode = op;
    fcode = fc;
    step();
    imem_ack = 1'b0;
    check("dec_state", state, 2);
    check("dec_ir_load", ir_load, 1);
    check("dec_pc_write", pc_write, 1);
    check("dec_pc_src", pc_src, 0);
    check("dec_req_drop", imem_req, 0);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [3:0] fc;
    logic [2:0] exp_state;
    logic       exp_illegal;
    logic       exp_halted;
  } dec_vec_t;

  dec_vec_t dec_tab[11] = '{
    '{3'd0, 4'd11, 3'd3, 1'b0, 1'b0},
    '{3'd0, 4'd12, 3'd6, 1'b1, 1'b1},
    '{3'd1, 4'd1,  3'd3, 1'b0, 1'b0},
    '{3'd1, 4'd2,  3'd6, 1'b1, 1'b1},
    '{3'd2, 4'd1,  3'd3, 1'b0, 1'b0},
    '{3'd2, 4'd2,  3'd6, 1'b1, 1'b1},
    '{3'd3, 4'd10, 3'd3, 1'b0, 1'b0},
    '{3'd3, 4'd11, 3'd6, 1'b1, 1'b1},
    '{3'd4, 4'd0,  3'd6, 1'b0, 1'b1},
    '{3'd5, 4'd0,  3'd6, 1'b1, 1'b1},
    '{3'd7, 4'd15, 3'd6, 1'b1, 1'b1}
  };

  initial begin
    step();
    step();
    apply_reset("por");

    // ALU op with writeback; fetch ack arrives two cycles after req
    do_fetch(3'd0, 4'd0, 2);
    step();
    check("alu_exec_state", state, 3);
    check("alu_start_hi", alu_start, 1);
    check("alu_ir_load_lo", ir_load, 0);
    check("alu_pc_write_lo", pc_write, 0);
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    check("alu_wb_state", state, 5);
    check("alu_reg_write", reg_write, 1);
    check("alu_flag_write", flag_write, 1);
    check("alu_mem_to_reg", mem_to_reg, 0);
    check("alu_start_lo", alu_start, 0);
    check("alu_retired_pre", retired_count, 0);
    step();
    check("alu_fetch_state", state, 1);
    check("alu_reg_write_lo", reg_write, 0);
    check("alu_flag_write_lo", flag_write, 0);
    check("alu_retired", retired_count, 1);
    check("alu_timeout_lo", timeout, 0);

    // load with dmem_ack on the third MEM cycle
    do_fetch(3'd2, 4'd0, 0);
    step();
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ld_mem_state", state, 4);
      check("ld_dmem_req", dmem_req, 1);
      check("ld_dmem_we", dmem_we, 0);
      if (i == 2) dmem_ack = 1'b1;
      step();
    end
    dmem_ack = 1'b0;
    check("ld_wb_state", state, 5);
    check("ld_dmem_req_lo", dmem_req, 0);
    check("ld_reg_write", reg_write, 1);
    check("ld_mem_to_reg", mem_to_reg, 1);
    check("ld_flag_write", flag_write, 0);
    step();
    check("ld_retired", retired_count, 2);

    // store; alu_done one cycle late, dmem_ack on the first MEM cycle
    do_fetch(3'd2, 4'd1, 1);
    step();
    check("st_alu_start", alu_start, 1);
    step();
    check("st_exec_hold", state, 3);
    check("st_alu_start_lo", alu_start, 0);
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    check("st_dmem_req", dmem_req, 1);
    check("st_dmem_we", dmem_we, 1);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("st_fetch_state", state, 1);
    check("st_dmem_req_lo", dmem_req, 0);
    check("st_reg_write_lo", reg_write, 0);
    check("st_retired", retired_count, 3);

    // branch taken, branch not taken, jr
    do_fetch(3'd3, 4'd3, 1);
    step();
    cond_true = 1'b1;
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    check("bt_state", state, 1);
    check("bt_pc_write", pc_write, 1);
    check("bt_pc_src", pc_src, 1);
    check("bt_reg_write", reg_write, 0);
    check("bt_retired", retired_count, 4);

    do_fetch(3'd3, 4'd3, 0);
    step();
    cond_true = 1'b0;
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    check("bn_state", state, 1);
    check("bn_pc_write", pc_write, 0);
    check("bn_reg_write", reg_write, 0);
    check("bn_retired", retired_count, 5);

    do_fetch(3'd3, 4'd0, 0);
    step();
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    check("jr_state", state, 1);
    check("jr_pc_write", pc_write, 1);
    check("jr_pc_src", pc_src, 2);
    check("jr_reg_write", reg_write, 0);
    check("jr_retired", retired_count, 6);
    step();
    check("jr_pc_write_lo", pc_write, 0);

    // illegal fcode halts; the block stays parked for 100 cycles even with ack noise
    do_fetch(3'd0, 4'd12, 0);
    step();
    check("ill_state", state, 6);
    check("ill_halted", halted, 1);
    check("ill_illegal", illegal, 1);
    check("ill_alu_start", alu_start, 0);
    for (int i = 0; i < 100; i++) begin
      imem_ack = i[0];
      step();
      check("halt_imem_req", imem_req, 0);
      check("halt_state", state, 6);
    end
    imem_ack = 1'b0;
    check("halt_retired", retired_count, 6);
    check("halt_sticky", halted, 1);

    // decode legality table, each from a fresh reset
    foreach (dec_tab[k]) begin
      apply_reset("dec_rst");
      do_fetch(dec_tab[k].op, dec_tab[k].fc, 0);
      step();
      check("dec_tab_state", state, dec_tab[k].exp_state);
      check("dec_tab_illegal", illegal, dec_tab[k].exp_illegal);
      check("dec_tab_halted", halted, dec_tab[k].exp_halted);
      check("dec_tab_alu_start", alu_start, (dec_tab[k].exp_state == 3'd3) ? 1 : 0);
    end

    // reset while a load holds dmem_req
    apply_reset("pre_mem");
    do_fetch(3'd2, 4'd1, 0);
    step();
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("mr_retired_pre", retired_count, 1);
    do_fetch(3'd2, 4'd0, 0);
    step();
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    step();
    check("mr_mem_state", state, 4);
    check("mr_dmem_req", dmem_req, 1);
    apply_reset("mid_mem");

`ifdef CTRL_TIMEOUT_EN
    // imem_ack never arrives: halt after 8 wait cycles
    for (int i = 1; i < 8; i++) begin
      step();
      check("to_wait_state", state, 1);
      check("to_wait_req", imem_req, 1);
    end
    step();
    check("to_state", state, 6);
    check("to_timeout", timeout, 1);
    check("to_halted", halted, 1);
    check("to_imem_req", imem_req, 0);
    check("to_illegal", illegal, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
